// File: rtl/toggle_pulse_gen.sv
// Push-button front end: synchronises and debounces a raw button and emits one
// single-cycle toggle pulse per confirmed press, plus the debounced level and a press count.
module toggle_pulse_gen #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_in,
  output logic             t,
  output logic             btn_level,
  output logic [CNT_W-1:0] press_count,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   press_evt, release_evt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // cnt counts stable samples beyond the first one; every state entry clears it.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    press_evt   = 1'b0;
    release_evt = 1'b0;
    case (state)
      IDLE: begin
        if (s) begin
          state_n = PRESS_WAIT;
          cnt_n   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n   = PRESSED;
          cnt_n     = '0;
          press_evt = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          state_n = RELEASE_WAIT;
          cnt_n   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n     = IDLE;
          cnt_n       = '0;
          release_evt = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // press_evt can only come from PRESS_WAIT, so t can never be high two cycles running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t           <= 1'b0;
      btn_level   <= 1'b0;
      press_count <= '0;
    end else begin
      t <= press_evt;
      if (press_evt)        btn_level <= 1'b1;
      else if (release_evt) btn_level <= 1'b0;
      if (press_evt) press_count <= press_count + CNT_W'(1);
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Bench for toggle_pulse_gen: a default instance plus a 2-bit-count instance share all inputs;
// expected press counts are queued at stimulus time and popped when a pulse appears.
module tb_toggle_pulse_gen;

  localparam int LAT = 2 + 4 + 1;  // posedges from driving a stable level to the visible output change

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_in;
  logic       t, btn_level, t_w, btn_level_w;
  logic [7:0] press_count;
  logic [1:0] press_count_w;
  logic [1:0] state_dbg, state_dbg_w;

  logic [7:0] exp_q[$];
  logic [1:0] exp2_q[$];
  logic [7:0] model_cnt;
  logic [1:0] model_cnt_w;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int exp_pulses = 0;
  int consec = 0;
  logic t_prev = 1'b0;
  logic tq;

  always #25 clk = ~clk;

  toggle_pulse_gen u_dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .t(t), .btn_level(btn_level),
    .press_count(press_count), .state_dbg(state_dbg)
  );

  toggle_pulse_gen #(.CNT_W(2)) u_dut_w (
    .clk(clk), .rst(rst), .btn_in(btn_in), .t(t_w), .btn_level(btn_level_w),
    .press_count(press_count_w), .state_dbg(state_dbg_w)
  );

  // Stand-in for the downstream T flip-flop.
  always @(posedge clk or posedge rst) begin
    if (rst)    tq <= 1'b0;
    else if (t) tq <= ~tq;
  end

  always @(negedge clk) begin
    if (t) pulse_cnt++;
    if (t && t_prev) consec++;
    t_prev = t;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_press();
    model_cnt   = model_cnt + 8'd1;
    model_cnt_w = model_cnt_w + 2'd1;
    exp_q.push_back(model_cnt);
    exp2_q.push_back(model_cnt_w);
  endtask

  task automatic model_reset();
    model_cnt   = '0;
    model_cnt_w = '0;
  endtask

  // Called right after the stable high level is driven.
  task automatic expect_press();
    int n;
    bit seen;
    logic [7:0] e1;
    logic [1:0] e2;
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (t) seen = 1;
    end
    chk("press_latency", n, LAT);
    chk("btn_level_high", btn_level, 1);
    chk("t_w_with_t", t_w, 1);
    e1 = exp_q.pop_front();
    e2 = exp2_q.pop_front();
    chk("press_count", press_count, e1);
    chk("press_count_w", press_count_w, e2);
    exp_pulses++;
    @(negedge clk);
    chk("t_width", t, 0);
  endtask

  // Called right after the final low level is driven.
  task automatic expect_release();
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (!btn_level) seen = 1;
    end
    chk("release_latency", n, LAT);
    chk("release_no_pulse", t, 0);
  endtask

  task automatic clean_press();
    btn_in = 1'b1;
    push_press();
    expect_press();
    cycles(3);
    btn_in = 1'b0;
    expect_release();
    cycles(2);
  endtask

  initial begin
    rst    = 1'b1;
    btn_in = 1'b1;
    model_reset();
    #1;
    chk("rst_t", t, 0);
    chk("rst_level", btn_level, 0);
    chk("rst_count", press_count, 0);
    #29;  // past the first edge, still in reset
    chk("rst_t_edge", t, 0);
    chk("rst_count_edge", press_count, 0);
    btn_in = 1'b0;
    #30 rst = 1'b0;

    // Clean press at 110 ns, held for 1 us.
    #50 btn_in = 1'b1;
    push_press();
    expect_press();
    #(1110 - $time);
    btn_in = 1'b0;
    expect_release();
    chk("tff_toggled", tq, 1);
    cycles(2);

    // Press bounce: high 3, low 1, then steady high.
    btn_in = 1'b1;
    cycles(3);
    btn_in = 1'b0;
    cycles(1);
    btn_in = 1'b1;
    push_press();
    expect_press();
    cycles(4);

    // Release bounce: low 2, high 1, then steady low.
    btn_in = 1'b0;
    cycles(2);
    chk("rel_bounce_level", btn_level, 1);
    btn_in = 1'b1;
    cycles(1);
    chk("rel_bounce_level2", btn_level, 1);
    btn_in = 1'b0;
    expect_release();
    chk("rel_bounce_count", press_count, model_cnt);
    cycles(2);

    // Wrap on the 2-bit instance: five presses from reset.
    rst = 1'b1;
    model_reset();
    cycles(2);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) clean_press();
    chk("wrap_final_w", press_count_w, 1);
    chk("wrap_final", press_count, 5);

    // Reset while debouncing a held press.
    btn_in = 1'b1;
    cycles(4);
    chk("in_press_wait", state_dbg, 1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_t", t, 0);
    chk("midrst_level", btn_level, 0);
    chk("midrst_count", press_count, 0);
    chk("midrst_state", state_dbg, 0);
    model_reset();
    cycles(2);
    rst = 1'b0;
    push_press();
    expect_press();
    cycles(20);
    chk("held_one_pulse", state_dbg, 2);
    btn_in = 1'b0;
    expect_release();
    cycles(2);

    chk("pulse_total", pulse_cnt, exp_pulses);
    chk("t_consecutive", consec, 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got %0t exp done", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/toggle_pulse_gen.md
# toggle_pulse_gen

Upstream stage that drives the `t` input of the team's T flip-flop (`t_ff`) from a raw, asynchronous, bouncy push-button. It synchronises the button, debounces it with a press/release state machine, and emits exactly one single-cycle `t` pulse per confirmed press. It also reports the debounced level and a wrapping press count.

## Interface
- `SYNC_STAGES`, 2: synchroniser depth, ≥2.
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronised samples required to confirm a change after the first sample, ≥1.
- `CNT_W`, 8: width of `press_count`.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `btn_in`  in  1  raw button, asynchronous to `clk`, may bounce.
- `t`  out  1  registered one-cycle toggle pulse; connects to `t_ff.t`.
- `btn_level`  out  1  registered debounced button level.
- `press_count`  out  CNT_W  number of confirmed presses, modulo 2^CNT_W.

## Operation
- Synchroniser: `btn_in` passes through a shift chain of `SYNC_STAGES` flops. The last stage is `s`. Only `s` feeds logic.
- Debounce counter `cnt` has width $clog2(DEBOUNCE_CYCLES)+1. It clears on every state entry.
- FSM states and transitions:
  - IDLE (released, stable): `s`=1 → PRESS_WAIT, `cnt`=0. Otherwise stay.
  - PRESS_WAIT: `s`=0 → IDLE (bounce rejected, no pulse). `s`=1 and `cnt`==DEBOUNCE_CYCLES-1 → PRESSED. Otherwise `s`=1 → `cnt`+1.
  - PRESSED (held, stable): `s`=0 → RELEASE_WAIT, `cnt`=0. Otherwise stay.
  - RELEASE_WAIT: `s`=1 → PRESSED (bounce rejected; no new pulse, no count). `s`=0 and `cnt`==DEBOUNCE_CYCLES-1 → IDLE. Otherwise `cnt`+1.
- On the PRESS_WAIT→PRESSED transition edge, the block sets three outputs on that same edge:
  - `t` ← 1
  - `btn_level` ← 1
  - `press_count` ← `press_count`+1
- `t` returns to 0 on the next edge unconditionally. `t` is never high on two consecutive cycles.
- On the RELEASE_WAIT→IDLE edge, `btn_level` ← 0. A release produces no pulse.
- `press_count` wraps from 2^CNT_W-1 to 0 with no flag.
- Unused state encodings → IDLE on the next edge with `cnt`=0.

## Timing
- Reset (asynchronous assert, immediate):
  - All synchroniser flops = 0.
  - FSM = IDLE, `cnt`=0.
  - `t`=0, `btn_level`=0, `press_count`=0.
- Reset deasserts synchronously in effect: the first state update happens on the first rising edge with `rst` low.
- Press latency: `btn_in` rises and is held, first sampled at edge k. `t` and `btn_level` go high after edge k+SYNC_STAGES+DEBOUNCE_CYCLES; `t` falls after the next edge. With defaults, `t` is high in the cycle after edge k+6.
- Release latency: `btn_level` falls after edge k+SYNC_STAGES+DEBOUNCE_CYCLES, counted from the first sampled low.
- Any glitch on `s` shorter than DEBOUNCE_CYCLES+1 consecutive samples is rejected.
- Reset mid-operation (any state, including the cycle `t`=1): all outputs clear immediately and no pulse completes. If the button is still held after reset, it is re-debounced from IDLE and produces a fresh pulse at the full press latency.
- Button held indefinitely: exactly one pulse; FSM stays in PRESSED.

## Test plan
- Reset: assert `rst` with `btn_in`=1. Required: `t`=0, `btn_level`=0, `press_count`=0 during reset and before any edge.
- Clean press, clk period 50 ns, defaults: `btn_in` 0→1 at 110 ns and held 1 µs. Required: one `t` pulse exactly 50 ns wide, `btn_level`=1, `press_count`=1, and `t_ff.q` toggles once.
- Bounce: `btn_in` pulses high for 3 cycles, low for 1, then high steadily. Required: no `t` during the bounce; one pulse counted from the steady edge; `press_count`=1.
- Release bounce: from PRESSED, `btn_in` low for 2 cycles, high for 1, then low. Required: no pulse, `press_count` unchanged, and `btn_level` falls 6 edges after the final low.
- Wrap: CNT_W=2, perform 5 clean presses. Required: `press_count` sequence 1, 2, 3, 0, 1 and exactly 5 pulses.
- Reset mid-press: assert `rst` in PRESS_WAIT while `btn_in` is held, release after 2 cycles. Required: outputs cleared, then one pulse 6 edges after the first post-reset edge, and `press_count`=1.
